bus_xbar_nslv: RTL and testbench
================================

# bus_xbar_nslv

Parametrised 1-master / N-slave native-bus splitter that replaces the fixed three-way core/natv/mmap/psram decode in the SoC top. It sits between `core_wrapper` and the peripheral wrappers, registers each core request, and decodes it against per-slave base/mask pairs. It adds features the fixed bus lacks: a per-access timeout watchdog, a default response for unmapped addresses, and a sticky error/IRQ record.

## Interface
- `NUM_SLV`, 4: number of slave ports (1..16).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `wstrb` width is `DATA_W/8`.
- `SLV_BASE`, all zeros: packed `NUM_SLV*ADDR_W`; slot i is the base of slave i.
- `SLV_MASK`, all zeros: packed `NUM_SLV*ADDR_W`; slot i is the compare mask of slave i.
- `TIMEOUT_CYC`, 255: maximum number of ACCESS cycles; 0 disables the timeout. Counter width is `$clog2(TIMEOUT_CYC+1)`.
- `DEF_RDATA`, 32'hDEAD_BEEF: read data returned on a decode miss or a timeout.

Ports:
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, synchronous and active-low.
- `mst_valid_i` in 1: master request; held until `mst_ready_o`.
- `mst_addr_i` in ADDR_W, `mst_wdata_i` in DATA_W, `mst_wstrb_i` in DATA_W/8: request fields; `wstrb`=0 means read.
- `mst_rdata_o` out DATA_W, `mst_ready_o` out 1: response; ready is a one-cycle pulse.
- `slv_valid_o` out NUM_SLV: one-hot slave request.
- `slv_addr_o` out ADDR_W, `slv_wdata_o` out DATA_W, `slv_wstrb_o` out DATA_W/8: shared registered request fields; the full address is passed, not an offset.
- `slv_rdata_i` in NUM_SLV*DATA_W, `slv_ready_i` in NUM_SLV: per-slave response.
- `err_irq_o` out 1: sticky error flag, level output.
- `err_addr_o` out ADDR_W: address of the most recent error.
- `err_clr_i` in 1: clears `err_irq_o`.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - On `mst_valid_i`=1, register addr/wdata/wstrb and the decode result.
  - Decode: slave i matches when `(addr & MASK[i]) == BASE[i]`. If several match, the lowest index wins.
  - Hit: go to ACCESS and latch the one-hot select.
  - Miss: go straight to RESP. Latch rdata=`DEF_RDATA`, record the error, and drop the write (no slave sees it).
- **ACCESS**
  - `slv_valid_o[sel]`=1; all other bits are 0. Shared fields stay stable.
  - The timeout counter increments every cycle.
  - On `slv_ready_i[sel]`: latch `slv_rdata_i[sel]`, drop valid, go to RESP.
  - When the counter reaches `TIMEOUT_CYC` without ready: drop valid, latch `DEF_RDATA`, record the error, go to RESP.
  - If ready arrives in the same cycle as the timeout, the ready wins and no error is recorded.
- **RESP**
  - `mst_ready_o`=1 for exactly one cycle with the latched `mst_rdata_o`, then return to IDLE.
  - The master must have dropped valid by the next cycle (PicoRV32 rule). Valid seen in IDLE is treated as a new request.
- `slv_ready_i` from an unselected slave, or outside ACCESS, is ignored.
- **Error recording**
  - Sets `err_irq_o` and overwrites `err_addr_o` with the request address.
  - `err_clr_i` clears `err_irq_o` only; `err_addr_o` holds its value.
  - If an error and `err_clr_i` occur in the same cycle, the set wins.

## Timing
- Reset (synchronous, `rst_n_i`=0 at an edge):
  - FSM goes to IDLE and the counter clears.
  - `slv_valid_o`=0, `mst_ready_o`=0, `mst_rdata_o`=0.
  - `slv_addr_o`/`slv_wdata_o`/`slv_wstrb_o`=0, `err_irq_o`=0, `err_addr_o`=0.
- Reset mid-ACCESS: `slv_valid_o` is 0 from the next edge and no `mst_ready_o` is issued for the aborted access.
- Hit latency, with valid first seen at edge T:
  - `slv_valid_o` is high in cycle T+1.
  - Slave ready in cycle T+k (k≥1) gives `mst_ready_o` in cycle T+k+1.
  - Minimum latency is 2 cycles.
- Miss latency: `mst_ready_o` in cycle T+1.
- Timeout latency: `slv_valid_o` high for exactly `TIMEOUT_CYC` cycles, then `mst_ready_o` in the next cycle.
- Throughput: at most one access per (latency+1) cycles; there is no pipelining across accesses.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
Common setup: `NUM_SLV`=3.
- Slave 0: BASE 0x0000_0000, MASK 0xFF00_0000.
- Slave 1: BASE 0x0300_0000, MASK 0xFF00_0000.
- Slave 2: BASE 0x0400_0000, MASK 0xFFF0_0000.
- `TIMEOUT_CYC`=8.

Scenarios:
- **Read hit:** read 0x0300_0010, slave 1 readies on its 1st valid cycle with 0x1234_5678 → `slv_valid_o`=3'b010 for 1 cycle; `mst_ready_o` 2 cycles after the request with rdata 0x1234_5678; `err_irq_o`=0.
- **Write hit:** write 0x0400_0004, wdata 0xA5A5_A5A5, wstrb 4'b0011, slave ready after 3 cycles → slave 2 sees identical, stable fields for all 3 cycles; `mst_ready_o` 4 cycles after the request.
- **Decode miss:** access 0x0800_0000 → no `slv_valid_o` bit set; `mst_ready_o` next cycle with 0xDEAD_BEEF; `err_irq_o`=1; `err_addr_o`=0x0800_0000.
- **Timeout:** slave 0 never readies → `slv_valid_o[0]` high for 8 cycles; `mst_ready_o` with 0xDEAD_BEEF; error set.
- **Timeout race:** slave 0 ready coincides with the 8th cycle → real rdata returned, no error.
- **Clear, error and reset interactions:**
  - `err_clr_i` asserted in the same cycle as a new miss → `err_irq_o` stays 1.
  - `err_clr_i` alone → `err_irq_o` is 0 next cycle and `err_addr_o` is unchanged.
  - `rst_n_i`=0 mid-ACCESS → all outputs read 0 after the edge and no spurious `mst_ready_o` appears.

Source files
------------

// File: rtl/bus_xbar_nslv.sv
// bus_xbar_nslv: one master to NUM_SLV slaves, registered native-bus splitter.
// Each request is decoded against per-slave base/mask pairs and served one at a
// time. A timeout watchdog bounds every slave access. Unmapped addresses are
// answered locally with DEF_RDATA. Errors are kept in a sticky IRQ/address record.
module bus_xbar_nslv #(
    parameter int                        NUM_SLV     = 4,
    parameter int                        ADDR_W      = 32,
    parameter int                        DATA_W      = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE    = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK    = '0,
    parameter int                        TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0]         DEF_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    // master side
    input  logic                        mst_valid_i,
    input  logic [ADDR_W-1:0]           mst_addr_i,
    input  logic [DATA_W-1:0]           mst_wdata_i,
    input  logic [DATA_W/8-1:0]         mst_wstrb_i,
    output logic [DATA_W-1:0]           mst_rdata_o,
    output logic                        mst_ready_o,
    // slave side
    output logic [NUM_SLV-1:0]          slv_valid_o,
    output logic [ADDR_W-1:0]           slv_addr_o,
    output logic [DATA_W-1:0]           slv_wdata_o,
    output logic [DATA_W/8-1:0]         slv_wstrb_o,
    input  logic [NUM_SLV*DATA_W-1:0]   slv_rdata_i,
    input  logic [NUM_SLV-1:0]          slv_ready_i,
    // error record
    output logic                        err_irq_o,
    output logic [ADDR_W-1:0]           err_addr_o,
    input  logic                        err_clr_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    // Keep at least one bit so a disabled timeout still elaborates cleanly.
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    state_t              state_q, state_d;
    req_t                req_q, req_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_SLV-1:0]  slv_valid_q, slv_valid_d;
    logic                mst_ready_q, mst_ready_d;
    logic [DATA_W-1:0]   mst_rdata_q, mst_rdata_d;
    logic                err_irq_q, err_irq_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic                dec_hit;
    logic [SEL_W-1:0]    dec_idx;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timeout_hit;
    logic                err_set;
    logic [ADDR_W-1:0]   err_set_addr;

    // Address decode: scan from the top so the lowest matching index wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((mst_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(i);
            end
        end
    end

    // Only the selected slave's response is looked at; everything else is ignored.
    assign sel_ready   = slv_ready_i[sel_q];
    assign sel_rdata   = slv_rdata_i[sel_q*DATA_W +: DATA_W];
    // cnt_q counts completed ACCESS cycles, so this is the TIMEOUT_CYC-th cycle.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (32'(cnt_q) == 32'(TIMEOUT_CYC - 1));

    // Next-state, output and error-record logic for the three-state access FSM.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        slv_valid_d  = slv_valid_q;
        mst_ready_d  = 1'b0;
        mst_rdata_d  = mst_rdata_q;
        err_irq_d    = err_irq_q;
        err_addr_d   = err_addr_q;
        err_set      = 1'b0;
        err_set_addr = req_q.addr;

        unique case (state_q)
            ST_IDLE: begin
                if (mst_valid_i) begin
                    req_d.addr  = mst_addr_i;
                    req_d.wdata = mst_wdata_i;
                    req_d.wstrb = mst_wstrb_i;
                    cnt_d       = '0;
                    if (dec_hit) begin
                        sel_d       = dec_idx;
                        slv_valid_d = NUM_SLV'(1) << dec_idx;
                        state_d     = ST_ACCESS;
                    end else begin
                        // Unmapped: answer locally, no slave ever sees the access.
                        mst_ready_d  = 1'b1;
                        mst_rdata_d  = DEF_RDATA;
                        err_set      = 1'b1;
                        err_set_addr = mst_addr_i;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // A ready in the final allowed cycle still counts as a success.
                if (sel_ready) begin
                    slv_valid_d = '0;
                    mst_ready_d = 1'b1;
                    mst_rdata_d = sel_rdata;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    slv_valid_d = '0;
                    mst_ready_d = 1'b1;
                    mst_rdata_d = DEF_RDATA;
                    err_set     = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                slv_valid_d = '0;
                state_d     = ST_IDLE;
            end
        endcase

        // A new error beats a clear arriving in the same cycle.
        if (err_set) begin
            err_irq_d  = 1'b1;
            err_addr_d = err_set_addr;
        end else if (err_clr_i) begin
            err_irq_d  = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            slv_valid_q <= '0;
            mst_ready_q <= 1'b0;
            mst_rdata_q <= '0;
            err_irq_q   <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            slv_valid_q <= slv_valid_d;
            mst_ready_q <= mst_ready_d;
            mst_rdata_q <= mst_rdata_d;
            err_irq_q   <= err_irq_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign slv_valid_o = slv_valid_q;
    assign slv_addr_o  = req_q.addr;
    assign slv_wdata_o = req_q.wdata;
    assign slv_wstrb_o = req_q.wstrb;
    assign mst_ready_o = mst_ready_q;
    assign mst_rdata_o = mst_rdata_q;
    assign err_irq_o   = err_irq_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_bus_xbar_nslv.sv
// Bench for bus_xbar_nslv: transaction-level model predicts every cycle's outputs.
module tb_bus_xbar_nslv;
    localparam int NS = 3;
    localparam int TO = 8;
    localparam logic [NS*32-1:0] BASE = {32'h0400_0000, 32'h0300_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hFFF0_0000, 32'hFF00_0000, 32'hFF00_0000};
    localparam logic [31:0]      DEF  = 32'hDEAD_BEEF;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            mst_valid = 1'b0;
    logic [31:0]     mst_addr = '0, mst_wdata = '0;
    logic [3:0]      mst_wstrb = '0;
    logic [31:0]     mst_rdata;
    logic            mst_ready;
    logic [NS-1:0]   slv_valid;
    logic [31:0]     slv_addr, slv_wdata;
    logic [3:0]      slv_wstrb;
    logic [NS*32-1:0] slv_rdata = '0;
    logic [NS-1:0]   slv_ready = '0;
    logic            err_irq;
    logic [31:0]     err_addr;
    logic            err_clr = 1'b0;

    bus_xbar_nslv #(
        .NUM_SLV(NS), .ADDR_W(32), .DATA_W(32), .SLV_BASE(BASE), .SLV_MASK(MASK),
        .TIMEOUT_CYC(TO), .DEF_RDATA(DEF)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .mst_valid_i(mst_valid), .mst_addr_i(mst_addr), .mst_wdata_i(mst_wdata),
        .mst_wstrb_i(mst_wstrb), .mst_rdata_o(mst_rdata), .mst_ready_o(mst_ready),
        .slv_valid_o(slv_valid), .slv_addr_o(slv_addr), .slv_wdata_o(slv_wdata),
        .slv_wstrb_o(slv_wstrb), .slv_rdata_i(slv_rdata), .slv_ready_i(slv_ready),
        .err_irq_o(err_irq), .err_addr_o(err_addr), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    // ---------------- model state / expectations ----------------
    logic [31:0] base_t [NS] = '{32'h0000_0000, 32'h0300_0000, 32'h0400_0000};
    logic [31:0] mask_t [NS] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFFF0_0000};

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, req_cyc = 0, cap_cyc = 0;
    logic [31:0] cap_rd = '0;
    bit          clr_en = 0;
    bit          exp_on = 0;
    logic [NS-1:0] exp_sv = '0;
    logic        exp_rdy = 0, exp_rd_chk = 0, exp_fchk = 0;
    logic [31:0] exp_rd = '0, exp_fa = '0, exp_fw = '0;
    logic [3:0]  exp_fs = '0;
    logic        m_irq = 0, exp_irq = 0;
    logic [31:0] m_ea = '0, exp_ea = '0;

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & mask_t[i]) == base_t[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Single compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (exp_on) begin
            chk("slv_valid", 32'(slv_valid), 32'(exp_sv));
            chk("mst_ready", 32'(mst_ready), 32'(exp_rdy));
            if (exp_rd_chk) chk("mst_rdata", mst_rdata, exp_rd);
            chk("err_irq", 32'(err_irq), 32'(exp_irq));
            chk("err_addr", err_addr, exp_ea);
            if (exp_fchk) begin
                chk("slv_addr", slv_addr, exp_fa);
                chk("slv_wdata", slv_wdata, exp_fw);
                chk("slv_wstrb", 32'(slv_wstrb), 32'(exp_fs));
            end
        end
        if (mst_ready) begin
            cap_rd  = mst_rdata;
            cap_cyc = cyc;
        end
    end

    // Advance one edge; the model's error record follows reset > set > clear.
    task automatic tick(input bit ev, input logic [31:0] ea);
        @(posedge clk);
        if (!rst_n) begin m_irq = 0; m_ea = '0; end
        else if (ev) begin m_irq = 1; m_ea = ea; end
        else if (err_clr) m_irq = 0;
        #1;
        exp_irq = m_irq;
        exp_ea  = m_ea;
    endtask

    task automatic set_exp(input logic [NS-1:0] sv, input logic rdy, input logic [31:0] rd);
        exp_sv = sv; exp_rdy = rdy; exp_rd = rd; exp_rd_chk = rdy; exp_fchk = 0;
    endtask

    task automatic noise();
        slv_ready = NS'($urandom);
        slv_rdata = {$urandom, $urandom, $urandom};
        err_clr   = clr_en && ($urandom_range(0, 5) == 0);
    endtask

    // One complete master access; d = cycle of slave ready within ACCESS (>TO: never).
    task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int d, input logic [31:0] data, input bit clr0);
        int s, n;
        bit tout;
        s = decode(a);
        noise();
        err_clr   = err_clr | clr0;
        mst_valid = 1; mst_addr = a; mst_wdata = wd; mst_wstrb = ws;
        req_cyc   = cyc;
        if (s < 0) begin
            tick(1, a);
            set_exp('0, 1, DEF);
            mst_valid = 0; noise();
            tick(0, '0);
            set_exp('0, 0, '0);
            return;
        end
        tick(0, '0);
        tout = (d > TO);
        n    = tout ? TO : d;
        for (int k = 1; k <= n; k++) begin
            set_exp(NS'(1) << s, 0, '0);
            exp_fchk = 1; exp_fa = a; exp_fw = wd; exp_fs = ws;
            noise();
            slv_ready[s] = (k == d);
            if (k == d) slv_rdata[s*32 +: 32] = data;
            tick(tout && (k == n), a);
        end
        set_exp('0, 1, tout ? DEF : data);
        mst_valid = 0; noise();
        tick(0, '0);
        set_exp('0, 0, '0);
    endtask

    task automatic idle_cycle();
        noise();
        tick(0, '0);
        set_exp('0, 0, '0);
    endtask

    initial begin
        logic [31:0] a;
        // reset
        rst_n = 0;
        tick(0, '0);
        tick(0, '0);
        set_exp('0, 0, '0); exp_rd_chk = 1; exp_fchk = 1; exp_fa = '0; exp_fw = '0; exp_fs = '0;
        exp_on = 1;
        rst_n = 1;
        tick(0, '0);
        set_exp('0, 0, '0); exp_rd_chk = 1; exp_fchk = 1;
        tick(0, '0);
        set_exp('0, 0, '0);

        // read hit
        xact(32'h0300_0010, 32'h0, 4'b0000, 1, 32'h1234_5678, 0);
        chk("pin_hit_rdata", cap_rd, 32'h1234_5678);
        chk("pin_hit_lat", 32'(cap_cyc - req_cyc), 32'd2);
        chk("pin_hit_irq", 32'(err_irq), 32'd0);
        // write hit, slave ready after 3 cycles
        xact(32'h0400_0004, 32'hA5A5_A5A5, 4'b0011, 3, 32'h0, 0);
        chk("pin_wr_lat", 32'(cap_cyc - req_cyc), 32'd4);
        // decode miss
        xact(32'h0800_0000, 32'h1, 4'b1111, 1, 32'h0, 0);
        chk("pin_miss_rdata", cap_rd, 32'hDEAD_BEEF);
        chk("pin_miss_lat", 32'(cap_cyc - req_cyc), 32'd1);
        chk("pin_miss_irq", 32'(err_irq), 32'd1);
        chk("pin_miss_addr", err_addr, 32'h0800_0000);
        // timeout
        xact(32'h0000_0040, 32'h0, 4'b0000, 100, 32'h0, 0);
        chk("pin_to_rdata", cap_rd, 32'hDEAD_BEEF);
        chk("pin_to_lat", 32'(cap_cyc - req_cyc), 32'd9);
        chk("pin_to_addr", err_addr, 32'h0000_0040);
        // clear alone
        err_clr = 1; slv_ready = '0;
        tick(0, '0); set_exp('0, 0, '0);
        err_clr = 0;
        chk("pin_clr_irq", 32'(err_irq), 32'd0);
        chk("pin_clr_addr", err_addr, 32'h0000_0040);
        // timeout race: ready on the 8th cycle wins
        xact(32'h0000_0080, 32'h0, 4'b0000, 8, 32'hCAFE_0008, 0);
        chk("pin_race_rdata", cap_rd, 32'hCAFE_0008);
        chk("pin_race_irq", 32'(err_irq), 32'd0);
        // clear together with a new miss: set wins
        xact(32'h0410_0000, 32'h0, 4'b0000, 1, 32'h0, 1);
        err_clr = 0;
        chk("pin_clrmiss_irq", 32'(err_irq), 32'd1);
        chk("pin_clrmiss_addr", err_addr, 32'h0410_0000);

        // reset in the middle of an access
        slv_ready = '0; err_clr = 0;
        mst_valid = 1; mst_addr = 32'h0000_0100; mst_wdata = 32'h55; mst_wstrb = 4'hF;
        tick(0, '0);
        for (int k = 1; k <= 3; k++) begin
            set_exp(3'b001, 0, '0);
            exp_fchk = 1; exp_fa = 32'h0000_0100; exp_fw = 32'h55; exp_fs = 4'hF;
            if (k == 3) begin rst_n = 0; mst_valid = 0; end
            tick(0, '0);
        end
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            set_exp('0, 0, '0); exp_rd_chk = 1; exp_fchk = 1; exp_fa = '0; exp_fw = '0; exp_fs = '0;
            if (k > 0) noise();
            tick(0, '0);
        end
        set_exp('0, 0, '0);

        // randomized traffic
        clr_en = 1;
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 4))
                0: a = {8'h00, 24'($urandom)};
                1: a = {8'h03, 24'($urandom)};
                2: a = {12'h040, 20'($urandom)};
                3: a = {12'h041, 20'($urandom)};
                default: a = $urandom;
            endcase
            xact(a, $urandom, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
                 $urandom_range(1, TO + 2), $urandom, 0);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
        end
        clr_en = 0; err_clr = 0;
        idle_cycle();
        exp_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of stimulus, expected completion");
        $fatal(1, "bench time limit");
    end
endmodule
